// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES key schedule, one 48-bit subkey per valid/ready handshake
module des_key_sched #(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy
);
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // bit i set where the FIPS shift schedule entry i is 1 (entries 0,1,8,15), else 2
  localparam logic [15:0] ONE_SH = 16'h8103;
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_cnt;
  logic [55:0] w_pc1, w_cd;
  logic [47:0] w_pc2;
  logic [3:0]  w_sidx;
  logic        w_two;
  logic        w_unused;
  function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
  function automatic logic [27:0] ror(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
  assign w_cd = {r_c, r_d};
  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign w_pc1[55-g] = key_in[64-PC1[g]];
  end
  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign w_pc2[47-g] = w_cd[56-PC2[g]];
  end
  // parity bits and the eight C/D bits PC-2 drops carry no information
  assign w_unused = ^{key_in[0], key_in[8], key_in[16], key_in[24], key_in[32], key_in[40],
                      key_in[48], key_in[56], w_cd[47], w_cd[38], w_cd[34], w_cd[31],
                      w_cd[21], w_cd[18], w_cd[13], w_cd[2]};
  assign w_sidx = EN ? r_cnt + 4'd1 : 4'd15 - r_cnt;
  assign w_two  = ~ONE_SH[w_sidx];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else if (r_state == IDLE) begin
      if (key_valid) begin
        r_c     <= EN ? rol(w_pc1[55:28], 1'b0) : w_pc1[55:28];
        r_d     <= EN ? rol(w_pc1[27:0], 1'b0) : w_pc1[27:0];
        r_cnt   <= '0;
        r_state <= RUN;
      end
    end else if (subkey_ready) begin
      if (r_cnt == 4'd15) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
        r_c   <= EN ? rol(r_c, w_two) : ror(r_c, w_two);
        r_d   <= EN ? rol(r_d, w_two) : ror(r_d, w_two);
      end
    end
  end
  assign key_ready    = r_state == IDLE;
  assign subkey_valid = r_state == RUN;
  assign busy         = subkey_valid;
  assign subkey       = subkey_valid ? w_pc2 : '0;
  assign subkey_idx   = subkey_valid ? r_cnt : '0;
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: both key-schedule directions in lockstep against a cumulative-rotation model
module tb_des_key_sched;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] K0  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KA  = 64'h123456789ABCDEF0;
  localparam logic [63:0] PAR = 64'h0101010101010101;
  logic        clk = 0, rst = 1, key_valid = 0, subkey_ready = 0;
  logic [63:0] key_in = '0;
  logic        kr [2], bz [2], sv [2];
  logic [47:0] sk [2];
  logic [3:0]  si [2];
  logic        m_busy = 0;
  logic [3:0]  m_idx = 0;
  logic [63:0] m_key = 0;
  logic [47:0] cap [2][16];
  logic [47:0] ref1 [16];
  int          vecs = 0, errs = 0, hs = 0, cyc;
  des_key_sched #(.EN(1'b1)) u1 (.clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(kr[1]), .subkey(sk[1]), .subkey_idx(si[1]), .subkey_valid(sv[1]),
    .subkey_ready(subkey_ready), .busy(bz[1]));
  des_key_sched #(.EN(1'b0)) u0 (.clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(kr[0]), .subkey(sk[0]), .subkey_idx(si[0]), .subkey_valid(sv[0]),
    .subkey_ready(subkey_ready), .busy(bz[0]));
  always #5 clk = ~clk;
  // round r subkey: PC-1 halves rotated left by the cumulative shift through round r, then PC-2
  function automatic logic [47:0] ks(input logic [63:0] k, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] o;
    int n;
    n = 0;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-PC1[i]];
      d[27-i] = k[64-PC1[28+i]];
    end
    for (int j = 0; j <= r; j++) n += SH[j];
    n = n % 28;
    c = (c << n) | (c >> (28 - n));
    d = (d << n) | (d >> (28 - n));
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
    return o;
  endfunction
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0;
      m_idx  <= 0;
    end else if (!m_busy && key_valid) begin
      m_busy <= 1;
      m_idx  <= 0;
      m_key  <= key_in;
    end else if (m_busy && subkey_ready) begin
      if (m_idx == 15) m_busy <= 0;
      else m_idx <= m_idx + 1;
    end
  end
  always @(negedge clk) begin
    for (int e = 0; e < 2; e++) begin
      chk($sformatf("key_ready[EN=%0d]", e), kr[e], !m_busy);
      chk($sformatf("busy[EN=%0d]", e), bz[e], m_busy);
      chk($sformatf("subkey_valid[EN=%0d]", e), sv[e], m_busy);
      chk($sformatf("subkey_idx[EN=%0d]", e), si[e], m_busy ? m_idx : 4'd0);
      chk($sformatf("subkey[EN=%0d]", e), sk[e],
          m_busy ? ks(m_key, e ? int'(m_idx) : 15 - int'(m_idx)) : 48'h0);
      if (sv[e] && subkey_ready) cap[e][si[e]] <= sk[e];
    end
    if (sv[1] && subkey_ready) hs <= hs + 1;
  end
  task automatic run_key(input logic [63:0] k, input bit stall, input bit junk, output int n);
    hs = 0;
    n = 0;
    key_in = k;
    key_valid = 1;
    subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      key_valid = junk;
      key_in = junk ? {$urandom, $urandom} : k;
      subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end while (m_busy && n < 400);
    key_valid = 0;
    if (n >= 400) chk("run_timeout", 48'(n), 48'd0);
    @(negedge clk);
    chk("handshakes", 48'(hs), 48'd16);
  endtask
  initial begin
    chk("model_k1", ks(K0, 0), 48'h1B02EFFC7072);
    chk("model_k2", ks(K0, 1), 48'h79AED9DBC9E5);
    chk("model_k16", ks(K0, 15), 48'hCB3D8B0E17F5);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    run_key(K0, 0, 1, cyc);
    chk("key_to_ready_cycles", 48'(cyc), 48'd17);
    chk("enc_idx0", cap[1][0], 48'h1B02EFFC7072);
    chk("enc_idx1", cap[1][1], 48'h79AED9DBC9E5);
    chk("enc_idx15", cap[1][15], 48'hCB3D8B0E17F5);
    chk("dec_idx0", cap[0][0], 48'hCB3D8B0E17F5);
    chk("dec_idx15", cap[0][15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk($sformatf("dec_reversed_%0d", i), cap[0][i], cap[1][15-i]);
    ref1 = cap[1];
    run_key(KA, 0, 0, cyc);
    for (int i = 0; i < 16; i++) ref1[i] = cap[1][i];
    run_key(KA ^ PAR, 0, 1, cyc);
    for (int i = 0; i < 16; i++) chk($sformatf("parity_ignored_%0d", i), cap[1][i], ref1[i]);
    run_key(K0, 1, 1, cyc);
    for (int i = 0; i < 16; i++) chk($sformatf("stalled_enc_%0d", i), cap[1][i], ks(K0, i));
    key_in = K0;
    key_valid = 1;
    subkey_ready = 1;
    @(posedge clk);
    #1 key_valid = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("rst_mid_valid", sv[1], 0);
    chk("rst_mid_subkey", sk[0], 0);
    chk("rst_mid_ready", kr[1], 1);
    run_key(K0, 0, 0, cyc);
    chk("restart_enc_k1", cap[1][0], 48'h1B02EFFC7072);
    chk("restart_dec_k16", cap[0][0], 48'hCB3D8B0E17F5);
    repeat (6) run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Iterative DES key schedule: accepts one 64-bit key and emits the 16 48-bit round subkeys, one per handshake.
- EN=1 emits K1..K16 in encryption order. EN=0 emits K16..K1 (the decryption direction) using right rotations, with no stored subkey table.
- Sits beside the permutation/round datapath. A round engine pulls one subkey per round over a valid/ready interface.

Parameters:
- EN, 1, 1 = encryption order (K1 first, left rotations); 0 = decryption order (K16 first, right rotations).

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- key_in  input  64  DES key; DES bit n (1 = MSB) is key_in[64-n]; parity bits 8,16,..,64 ignored
- key_valid  input  1  key_in valid
- key_ready  output  1  block idle and able to accept a key
- subkey  output  48  current subkey; DES bit n is subkey[48-n]
- subkey_idx  output  4  emission index 0..15 (EN=1: round idx+1; EN=0: round 16-idx)
- subkey_valid  output  1  subkey/subkey_idx valid
- subkey_ready  input  1  consumer accepts subkey
- busy  output  1  high while subkeys are pending (state RUN)

Behaviour:
- **Tables:** PC-1, PC-2 and the shift schedule s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 are per FIPS 46-3. C and D are 28-bit registers; cnt is a 4-bit counter.
- **FSM states:** IDLE, RUN. rst forces IDLE with cnt=0 and C=D=0, from any state, including mid-sequence. Any partially emitted sequence is abandoned.
- **Outputs vs. state:**
  - key_ready = (state==IDLE).
  - busy = subkey_valid = (state==RUN).
  - subkey = PC2(C,D) when subkey_valid, else 48'h0.
  - subkey_idx = cnt when subkey_valid, else 0.
- **Output values:** after the reset edge, key_ready=1, busy=0, subkey_valid=0, subkey=0, subkey_idx=0.
- **Key load (IDLE, key_valid & key_ready at edge N):**
  - {C,D} <= PC1(key_in), then C and D each rotated left by 1 if EN=1; no rotation if EN=0.
  - cnt <= 0; go to RUN.
  - First subkey_valid is at cycle N+1 (latency 1). key_valid while not key_ready is ignored.
- **Emission (RUN, subkey_valid & subkey_ready at edge):**
  - If cnt==15: go to IDLE, cnt <= 0. key_ready rises the next cycle; there is no key accept in the same cycle as the last subkey handshake.
  - Else cnt <= cnt+1, and C,D are updated:
    - EN=1: rotate left by s[cnt+1] (0-based table index).
    - EN=0: rotate right by s[15-cnt].
- **Backpressure:** while subkey_ready=0, C, D, cnt, subkey and subkey_idx hold stable. subkey_valid never drops before its handshake.
- **Throughput:** 16 subkeys in 16 consecutive cycles with subkey_ready tied high. Minimum key-to-key period is 17 cycles.
- **Invariant:** cumulative rotation across all 16 subkeys is 28 positions for both EN values. After the final subkey, C,D equal the PC1 value rotated per the sequence end; they are not reused.
- **Rotation widths:** rotations are within each 28-bit half only; C and D never exchange bits.
- **No combinational path:** key_in has no combinational path to any output; subkey depends on registers only.

Test Plan:
- EN=1, key 64'h133457799BBCDFF1, subkey_ready=1 -> cycle N+1: idx0 subkey 48'h1B02EFFC7072; idx1 48'h79AED9DBC9E5; idx15 48'hCB3D8B0E17F5; key_ready high at N+17.
- EN=0, same key -> idx0 48'hCB3D8B0E17F5, idx15 48'h1B02EFFC7072. The full 16-subkey list equals the EN=1 list reversed.
- EN=1, key 64'h123456789ABCDEF0 vs. same key with all parity bits (LSB of each byte) inverted -> identical 16 subkeys.
- Backpressure: random subkey_ready (about 50% duty) -> each subkey/idx holds stable while stalled; exactly 16 handshakes; same values as the unstalled run.
- Key offered during RUN (key_valid=1 with a different key) -> key_ready=0, key ignored, sequence unchanged. The second key is accepted only when key_ready=1 after idx15.
- rst asserted after idx5 handshake -> next cycle subkey_valid=0, subkey=0, key_ready=1. A new key then restarts from idx0 with the correct K1 (EN=1) or K16 (EN=0).
